game_timer_ctrl: RTL and testbench

GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

---
 rtl/game_timer_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_game_timer_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer_ctrl.sv
// -----------------------------------------------------------------------------
// game_timer_ctrl
//
// Purpose
//   Level countdown timer plus a shared two-requester delay engine.
//   - A free-running prescaler produces tickPulse every TICK_CYCLES clocks.
//   - A second counter (frozen by pause) turns TICKS_PER_SEC ticks into one
//     game second and decrements currentTime, holding at zero.
//   - The delay engine serves one delay at a time for requester A (game FSM)
//     or B (transition sequencer). A has fixed priority. Each delay counts
//     tickPulse events and ends with a one-cycle doneA/doneB pulse.
//
// Configuration
//   GAME_TIMER_BCD_EN : when defined, currentTime is six packed BCD digits
//                       (bits 23:20 most significant); otherwise plain binary.
//
// Ports
//   clk          in   system clock
//   resetN       in   asynchronous active-low reset
//   pause        in   freezes the level countdown (not the prescaler)
//   levelStart   in   pulse, reloads currentTime and clears the second counter
//   reqA/_ticks  in   delay request A and its length in ticks
//   reqB/_ticks  in   delay request B and its length in ticks
//   doneA/doneB  out  one-cycle pulse when the granted delay expires
//   busy         out  delay engine active or holding a pending request
//   tickPulse    out  one-cycle pulse every TICK_CYCLES clocks
//   currentTime  out  seconds remaining (binary or BCD)
//   timeUp       out  one-cycle pulse when currentTime reaches zero
// -----------------------------------------------------------------------------
module game_timer_ctrl #(
  parameter int TICK_CYCLES    = 5_000_000,
  parameter int TICKS_PER_SEC  = 10,
  parameter int LEVEL_TIME_SEC = 120
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        pause,
  input  logic        levelStart,
  input  logic        reqA,
  input  logic [10:0] reqA_ticks,
  input  logic        reqB,
  input  logic [10:0] reqB_ticks,
  output logic        doneA,
  output logic        doneB,
  output logic        busy,
  output logic        tickPulse,
  output logic [23:0] currentTime,
  output logic        timeUp
);

  localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SEC_W   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_CYCLES - 1);
  localparam logic [SEC_W-1:0]   SEC_MAX   = SEC_W'(TICKS_PER_SEC - 1);

`ifdef GAME_TIMER_BCD_EN
  // Elaboration-time conversion of the reload value into packed BCD.
  function automatic logic [23:0] to_bcd(input int value);
    logic [23:0] res;
    int          rem;
    res = '0;
    rem = value;
    for (int d = 0; d < 6; d++) begin
      res[d*4 +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return res;
  endfunction
  localparam logic [23:0] TIME_LOAD = to_bcd(LEVEL_TIME_SEC);
`else
  localparam logic [23:0] TIME_LOAD = 24'(LEVEL_TIME_SEC);
`endif

  typedef enum logic [1:0] {IDLE, RUN_A, RUN_B, DONE} state_t;

  // ---------------------------------------------------------------------------
  // Prescaler: free running, never affected by pause.
  // ---------------------------------------------------------------------------
  logic [PRESC_W-1:0] r_presc;
  logic               r_tick;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
      r_tick  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Level countdown
  // ---------------------------------------------------------------------------
  logic [SEC_W-1:0] r_sec;
  logic [23:0]      r_time;
  logic             r_time_up;
  logic [23:0]      w_time_dec;
  logic             w_sec_adv;
  logic             w_sec_strobe;

  assign w_sec_adv    = r_tick && !pause;
  assign w_sec_strobe = w_sec_adv && (r_sec == SEC_MAX);

`ifdef GAME_TIMER_BCD_EN
  // Ripple-borrow BCD decrement; only used while r_time is non-zero, so the
  // borrow never escapes the top digit.
  logic [6:0] w_borrow;
  assign w_borrow[0] = 1'b1;
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_bcd_digit
      logic [3:0] w_digit;
      assign w_digit = r_time[gi*4 +: 4];
      assign w_time_dec[gi*4 +: 4] = !w_borrow[gi]     ? w_digit :
                                     (w_digit == 4'd0) ? 4'd9    :
                                                         w_digit - 4'd1;
      assign w_borrow[gi+1] = w_borrow[gi] && (w_digit == 4'd0);
    end
  endgenerate
`else
  assign w_time_dec = r_time - 24'd1;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_sec     <= '0;
      r_time    <= TIME_LOAD;
      r_time_up <= 1'b0;
    end else begin
      r_time_up <= 1'b0;
      // levelStart takes precedence over a coincident second strobe.
      if (levelStart) begin
        r_sec  <= '0;
        r_time <= TIME_LOAD;
      end else if (w_sec_strobe) begin
        r_sec <= '0;
        if (r_time != 24'd0) begin
          r_time    <= w_time_dec;
          // 1 is encoded identically in binary and BCD.
          r_time_up <= (r_time == 24'd1);
        end
      end else if (w_sec_adv) begin
        r_sec <= r_sec + SEC_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Delay engine
  // A pending bit is consumed when its delay is granted; the running delay
  // then carries the request until DONE. A fresh request from the owner while
  // it runs simply sets the pending bit again and is served afterwards, so the
  // running delay is never restarted. A request in the same cycle as a grant
  // wins over the grant's clear (it is a new request).
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic        r_pend_a;
  logic        r_pend_b;
  logic [10:0] r_ticks_a;
  logic [10:0] r_ticks_b;
  logic [10:0] r_cnt;
  logic        r_done_a;
  logic        r_done_b;
  logic        r_busy;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= IDLE;
      r_pend_a  <= 1'b0;
      r_pend_b  <= 1'b0;
      r_ticks_a <= '0;
      r_ticks_b <= '0;
      r_cnt     <= '0;
      r_done_a  <= 1'b0;
      r_done_b  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
      // Busy also covers queued work, so it stays high across the single
      // IDLE cycle between back-to-back delays.
      r_busy <= (r_state == RUN_A) || (r_state == RUN_B) ||
                r_pend_a || r_pend_b || reqA || reqB;

      case (r_state)
        IDLE: begin
          if (r_pend_a) begin
            r_state  <= RUN_A;
            r_cnt    <= r_ticks_a;
            r_pend_a <= 1'b0;
          end else if (r_pend_b) begin
            r_state  <= RUN_B;
            r_cnt    <= r_ticks_b;
            r_pend_b <= 1'b0;
          end
        end
        RUN_A, RUN_B: begin
          if (r_cnt == 11'd0) begin
            r_state  <= DONE;
            r_done_a <= (r_state == RUN_A);
            r_done_b <= (r_state == RUN_B);
          end else if (r_tick) begin
            r_cnt <= r_cnt - 11'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (reqA) begin
        r_pend_a  <= 1'b1;
        r_ticks_a <= reqA_ticks;
      end
      if (reqB) begin
        r_pend_b  <= 1'b1;
        r_ticks_b <= reqB_ticks;
      end
    end
  end

  assign doneA       = r_done_a;
  assign doneB       = r_done_b;
  assign busy        = r_busy;
  assign tickPulse   = r_tick;
  assign currentTime = r_time;
  assign timeUp      = r_time_up;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_timer_ctrl
//   Directed vector table, hand-written corner sequences and a randomized run
//   checked against a timeline reference model (absolute edge numbers).
// -----------------------------------------------------------------------------
module tb_game_timer_ctrl;
  localparam int TC  = 4;
  localparam int TPS = 2;
  localparam int LVL = 3;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        pause = 1'b0;
  logic        levelStart = 1'b0;
  logic        reqA = 1'b0;
  logic [10:0] reqA_ticks = '0;
  logic        reqB = 1'b0;
  logic [10:0] reqB_ticks = '0;
  logic        doneA, doneB, busy, tickPulse, timeUp;
  logic [23:0] currentTime;

  int ntests = 0;
  int nfail  = 0;

  game_timer_ctrl #(
    .TICK_CYCLES(TC),
    .TICKS_PER_SEC(TPS),
    .LEVEL_TIME_SEC(LVL)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .pause(pause),
    .levelStart(levelStart),
    .reqA(reqA),
    .reqA_ticks(reqA_ticks),
    .reqB(reqB),
    .reqB_ticks(reqB_ticks),
    .doneA(doneA),
    .doneB(doneB),
    .busy(busy),
    .tickPulse(tickPulse),
    .currentTime(currentTime),
    .timeUp(timeUp)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (timeline based) ----------------
  int e;               // clock edges since reset release
  bit m_pend_a, m_pend_b;
  int m_ticks_a, m_ticks_b;
  bit m_active, m_owner_b;
  int m_d, m_free;     // edge where done is raised; first edge a grant may occur
  int m_time, m_sec;
  bit m_timeup;

  function automatic logic [23:0] enc(input int v);
    logic [23:0] r;
    int          x;
    r = '0;
    x = v;
`ifdef GAME_TIMER_BCD_EN
    for (int d = 0; d < 6; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
`else
    r = 24'(x);
`endif
    return r;
  endfunction

  // A tick is seen by logic clocked at edge t when tickPulse rose at edge t-1.
  function automatic bit tick_at(input int t);
    return (t - 1 >= 1) && ((t - 1) % TC == 0);
  endfunction

  // Done edge for a delay of n ticks granted at edge g.
  function automatic int done_edge(input int g, input int n);
    int t, c;
    if (n == 0) return g + 1;
    t = g;
    c = 0;
    while (c < n) begin
      t++;
      if (tick_at(t)) c++;
    end
    return t + 1;
  endfunction

  task automatic model_reset();
    e = 0;
    m_pend_a = 0; m_pend_b = 0; m_ticks_a = 0; m_ticks_b = 0;
    m_active = 0; m_owner_b = 0; m_d = 0; m_free = 1;
    m_time = LVL; m_sec = 0; m_timeup = 0;
  endtask

  task automatic model_edge();
    e++;
    if (m_active && e > m_d) m_active = 0;
    if (!m_active && e >= m_free && (m_pend_a || m_pend_b)) begin
      m_active  = 1;
      m_owner_b = !m_pend_a;
      m_d       = done_edge(e, m_pend_a ? m_ticks_a : m_ticks_b);
      m_free    = m_d + 2;
      if (m_pend_a) m_pend_a = 0; else m_pend_b = 0;
    end
    if (reqA) begin m_pend_a = 1; m_ticks_a = int'(reqA_ticks); end
    if (reqB) begin m_pend_b = 1; m_ticks_b = int'(reqB_ticks); end
    m_timeup = 0;
    if (levelStart) begin
      m_time = LVL;
      m_sec  = 0;
    end else if (tick_at(e) && !pause) begin
      m_sec++;
      if (m_sec == TPS) begin
        m_sec = 0;
        if (m_time > 0) begin
          m_time--;
          m_timeup = (m_time == 0);
        end
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp_v);
    ntests++;
    if (act !== exp_v) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp_v, e);
    end
  endtask

  task automatic check_model(input string nm);
    chk({nm, "_doneA"}, 24'(doneA), 24'(m_active && !m_owner_b && e == m_d));
    chk({nm, "_doneB"}, 24'(doneB), 24'(m_active && m_owner_b && e == m_d));
    chk({nm, "_busy"},  24'(busy),  24'(m_active || m_pend_a || m_pend_b));
    chk({nm, "_tick"},  24'(tickPulse), 24'(e > 0 && e % TC == 0));
    chk({nm, "_time"},  currentTime, enc(m_time));
    chk({nm, "_timeUp"}, 24'(timeUp), 24'(m_timeup));
  endtask

  task automatic clear_inputs();
    reqA = 0; reqB = 0; reqA_ticks = '0; reqB_ticks = '0;
    pause = 0; levelStart = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    resetN = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_model("reset");
    resetN = 1;
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset(input string nm);
    resetN = 0;
    #1;
    model_reset();
    check_model(nm);
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    resetN = 1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ra;
    logic [10:0] rat;
    logic        rb;
    logic [10:0] rbt;
    logic        d_a;
    logic        d_b;
    logic        bz;
    logic        tk;
    int          tm;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mkv(input logic ra, input int rat, input logic rb, input int rbt,
                               input logic d_a, input logic d_b, input logic bz,
                               input logic tk, input int tm);
    vec_t v;
    v.ra = ra; v.rat = 11'(rat); v.rb = rb; v.rbt = 11'(rbt);
    v.d_a = d_a; v.d_b = d_b; v.bz = bz; v.tk = tk; v.tm = tm;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    // Row i is applied before edge i+1 and checked just after it.
    // Zero-tick B request, then a 1-tick A request.
    tbl[0]  = mkv(0, 0, 1, 0, 0, 0, 1, 0, 3);
    tbl[1]  = mkv(0, 0, 0, 0, 0, 0, 1, 0, 3);
    tbl[2]  = mkv(0, 0, 0, 0, 0, 1, 1, 0, 3);
    tbl[3]  = mkv(0, 0, 0, 0, 0, 0, 0, 1, 3);
    tbl[4]  = mkv(1, 1, 0, 0, 0, 0, 1, 0, 3);
    tbl[5]  = mkv(0, 0, 0, 0, 0, 0, 1, 0, 3);
    tbl[6]  = mkv(0, 0, 0, 0, 0, 0, 1, 0, 3);
    tbl[7]  = mkv(0, 0, 0, 0, 0, 0, 1, 1, 3);
    tbl[8]  = mkv(0, 0, 0, 0, 0, 0, 1, 0, 2);
    tbl[9]  = mkv(0, 0, 0, 0, 1, 0, 1, 0, 2);
    tbl[10] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 2);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      reqA = tbl[i].ra; reqA_ticks = tbl[i].rat;
      reqB = tbl[i].rb; reqB_ticks = tbl[i].rbt;
      step();
      ntests++;
      if (doneA !== tbl[i].d_a || doneB !== tbl[i].d_b || busy !== tbl[i].bz ||
          tickPulse !== tbl[i].tk || currentTime !== enc(tbl[i].tm)) begin
        nfail++;
        $display("FAIL vec%0d: got dA=%b dB=%b busy=%b tick=%b time=%0h expected dA=%b dB=%b busy=%b tick=%b time=%0h",
                 i, doneA, doneB, busy, tickPulse, currentTime,
                 tbl[i].d_a, tbl[i].d_b, tbl[i].bz, tbl[i].tk, enc(tbl[i].tm));
      end
    end
    clear_inputs();

    // Countdown 3,2,1,0 every 8 cycles, single timeUp, hold at 0 for 40 more.
    do_reset();
    for (int k = 1; k <= 65; k++) begin
      step();
      chk("cd_time", currentTime, enc(k < 9 ? 3 : k < 17 ? 2 : k < 25 ? 1 : 0));
      chk("cd_timeUp", 24'(timeUp), 24'(k == 25));
    end

    // Pause for 20 cycles: time frozen, ticks keep coming.
    do_reset();
    repeat (10) step();
    pause = 1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("pause_time", currentTime, enc(2));
      if (tickPulse) cnt++;
    end
    pause = 0;
    chk("pause_ticks", 24'(cnt), 24'd5);

    // Simultaneous A(2 ticks) and B(1 tick): A first, busy held throughout.
    do_reset();
    reqA = 1; reqA_ticks = 11'd2; reqB = 1; reqB_ticks = 11'd1;
    for (int k = 1; k <= 16; k++) begin
      step();
      reqA = 0; reqB = 0;
      chk("ab_doneA", 24'(doneA), 24'(k == 10));
      chk("ab_doneB", 24'(doneB), 24'(k == 14));
      chk("ab_busy", 24'(busy), 24'(k <= 14));
    end

    // Reset in the middle of RUN_A: no doneA afterwards.
    do_reset();
    reqA = 1; reqA_ticks = 11'd5;
    step();
    reqA = 0;
    repeat (5) step();
    async_reset("rst_mid");
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      check_model("post_rst");
      if (doneA) cnt++;
    end
    chk("post_rst_doneA_count", 24'(cnt), 24'd0);

    // levelStart coincides with the strobe that would take time 1 -> 0.
    do_reset();
    repeat (24) step();
    chk("ls_pre_time", currentTime, enc(1));
    levelStart = 1;
    step();
    levelStart = 0;
    chk("ls_time", currentTime, enc(3));
    chk("ls_timeUp", 24'(timeUp), 24'd0);
    repeat (7) step();
    chk("ls_time_e32", currentTime, enc(3));
    step();
    chk("ls_time_e33", currentTime, enc(2));

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reqA = ($urandom_range(0, 11) == 0);
      reqA_ticks = 11'($urandom_range(0, 5));
      reqB = ($urandom_range(0, 11) == 0);
      reqB_ticks = 11'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      levelStart = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 699) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step();
        check_model("rnd");
      end
    end
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
